// File: rtl/pong_game_fsm.sv
// Game-level sequencer for pong: serve control, wall-miss detection, scoring, winner.
// Latency: every output is registered; a miss seen in cycle N shows as score/pulse in cycle N+1.
// Backpressure: none; the ball and paddle inputs are sampled every cycle, no handshake.
module pong_game_fsm #(
  parameter int c_game_width    = 40,
  parameter int c_game_height   = 30,
  parameter int c_paddle_height = 6,
  parameter int c_score_limit   = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [5:0] i_ball_x,
  input  logic [5:0] i_ball_y,
  input  logic [5:0] i_paddle_y_p1,
  input  logic [5:0] i_paddle_y_p2,
  output logic       o_game_active,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic       o_point_p1,
  output logic       o_point_p2,
  output logic [1:0] o_winner
);

  // Reject parameter sets the 6-bit coordinates or 4-bit scores cannot represent.
  if ((c_score_limit < 1) || (c_score_limit > 15) ||
      (c_game_width < 1) || (c_game_width > 64) ||
      (c_game_height < 1) || (c_game_height > 64) ||
      (c_paddle_height < 1) || (c_paddle_height > 64)) begin : g_bad_param
    $error("pong_game_fsm: parameter out of range");
  end

  localparam logic [5:0] c_x_right   = 6'(c_game_width - 1);
  localparam logic [6:0] c_pad_span  = 7'(c_paddle_height - 1);
  localparam logic [3:0] c_limit     = 4'(c_score_limit);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_POINT   = 3'd2,
    ST_P1_WINS = 3'd3,
    ST_P2_WINS = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       start_q;
  logic       active_q, active_d;
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;
  logic       point_p1_q, point_p1_d;
  logic       point_p2_q, point_p2_d;
  logic [1:0] winner_q, winner_d;

  logic       start_edge;
  logic       hit_p1, hit_p2;
  logic       miss_left, miss_right;
  logic [6:0] ball_y_w, pad1_w, pad2_w;

  assign start_edge = i_start & ~start_q;

  // Paddle extent computed in 7 bits so a paddle parked near row 63 cannot wrap.
  assign ball_y_w = {1'b0, i_ball_y};
  assign pad1_w   = {1'b0, i_paddle_y_p1};
  assign pad2_w   = {1'b0, i_paddle_y_p2};
  assign hit_p1   = (ball_y_w >= pad1_w) && (ball_y_w <= pad1_w + c_pad_span);
  assign hit_p2   = (ball_y_w >= pad2_w) && (ball_y_w <= pad2_w + c_pad_span);

  // With a one-column field both could fire; the left wall takes priority downstream.
  assign miss_left  = (i_ball_x == 6'd0) && !hit_p1;
  assign miss_right = (i_ball_x == c_x_right) && !hit_p2;

  // State and registered outputs; reset also discards any start edge in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      active_q   <= 1'b0;
      p1_score_q <= 4'd0;
      p2_score_q <= 4'd0;
      point_p1_q <= 1'b0;
      point_p2_q <= 1'b0;
      winner_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      start_q    <= i_start;
      active_q   <= active_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      point_p1_q <= point_p1_d;
      point_p2_q <= point_p2_d;
      winner_q   <= winner_d;
    end
  end

  // Next-state: serve from IDLE, score on a miss, one-cycle POINT, then match end or re-serve.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (miss_left || miss_right) state_d = ST_POINT;
      end
      ST_POINT: begin
        if (p1_score_q == c_limit)      state_d = ST_P1_WINS;
        else if (p2_score_q == c_limit) state_d = ST_P2_WINS;
        else                            state_d = ST_IDLE;
      end
      ST_P1_WINS, ST_P2_WINS: begin
        if (start_edge) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values: active/winner follow the next state, scores move only on a RUNNING miss.
  always_comb begin
    active_d   = (state_d == ST_RUNNING);
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    point_p1_d = 1'b0;
    point_p2_d = 1'b0;
    case (state_d)
      ST_P1_WINS: winner_d = 2'b01;
      ST_P2_WINS: winner_d = 2'b10;
      default:    winner_d = 2'b00;
    endcase
    case (state_q)
      ST_RUNNING: begin
        if (miss_left) begin
          p2_score_d = p2_score_q + 4'd1;
          point_p2_d = 1'b1;
        end else if (miss_right) begin
          p1_score_d = p1_score_q + 4'd1;
          point_p1_d = 1'b1;
        end
      end
      ST_P1_WINS, ST_P2_WINS: begin
        if (start_edge) begin
          p1_score_d = 4'd0;
          p2_score_d = 4'd0;
        end
      end
      default: begin
      end
    endcase
  end

  assign o_game_active = active_q;
  assign o_p1_score    = p1_score_q;
  assign o_p2_score    = p2_score_q;
  assign o_point_p1    = point_p1_q;
  assign o_point_p2    = point_p2_q;
  assign o_winner      = winner_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Scoreboard bench for pong_game_fsm: directed test-plan sequences followed by random play.
// Expected outputs come from a rule-level model that tracks only the visible game facts.
module tb_pong_game_fsm;

  localparam int W   = 40;
  localparam int PH  = 6;
  localparam int LIM = 9;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [5:0] i_ball_x = 6'd20;
  logic [5:0] i_ball_y = 6'd0;
  logic [5:0] i_paddle_y_p1 = 6'd0;
  logic [5:0] i_paddle_y_p2 = 6'd0;
  logic       o_game_active;
  logic [3:0] o_p1_score, o_p2_score;
  logic       o_point_p1, o_point_p2;
  logic [1:0] o_winner;

  pong_game_fsm #(
    .c_game_width(W), .c_game_height(30), .c_paddle_height(PH), .c_score_limit(LIM)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_ball_x(i_ball_x), .i_ball_y(i_ball_y),
    .i_paddle_y_p1(i_paddle_y_p1), .i_paddle_y_p2(i_paddle_y_p2),
    .o_game_active(o_game_active), .o_p1_score(o_p1_score), .o_p2_score(o_p2_score),
    .o_point_p1(o_point_p1), .o_point_p2(o_point_p2), .o_winner(o_winner)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       act;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       pt1;
    logic       pt2;
    logic [1:0] win;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: just what a spectator sees (scores, winner, pulses, play light) plus the button.
  int m_s1 = 0, m_s2 = 0, m_win = 0;
  bit m_act = 0, m_pt1 = 0, m_pt2 = 0, m_sprev = 0;

  task automatic model_step(input bit rst, input bit st, input int bx, input int by,
                            input int py1, input int py2);
    bit edge_s, hit1, hit2;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_win = 0;
      m_act = 0; m_pt1 = 0; m_pt2 = 0; m_sprev = 0;
      return;
    end
    edge_s  = st && !m_sprev;
    m_sprev = st;
    if (m_pt1 || m_pt2) begin
      // the cycle after a pulse: decide whether the match is over
      m_pt1 = 0; m_pt2 = 0; m_act = 0;
      if (m_s1 == LIM)      m_win = 1;
      else if (m_s2 == LIM) m_win = 2;
    end else if (m_act) begin
      hit1 = (by >= py1) && (by <= py1 + PH - 1);
      hit2 = (by >= py2) && (by <= py2 + PH - 1);
      if (bx == 0 && !hit1) begin
        m_s2++; m_pt2 = 1; m_act = 0;
      end else if (bx == W - 1 && !hit2) begin
        m_s1++; m_pt1 = 1; m_act = 0;
      end
    end else if (m_win != 0) begin
      if (edge_s) begin m_s1 = 0; m_s2 = 0; m_win = 0; end
    end else begin
      if (edge_s) m_act = 1;
    end
  endtask

  task automatic cyc(input bit rst, input bit st, input int bx, input int by,
                     input int py1, input int py2);
    exp_t e;
    @(negedge i_clk);
    i_rst = rst; i_start = st;
    i_ball_x = 6'(bx); i_ball_y = 6'(by);
    i_paddle_y_p1 = 6'(py1); i_paddle_y_p2 = 6'(py2);
    model_step(rst, st, bx, by, py1, py2);
    e.act = m_act; e.s1 = 4'(m_s1); e.s2 = 4'(m_s2);
    e.pt1 = m_pt1; e.pt2 = m_pt2; e.win = 2'(m_win);
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {o_game_active, o_p1_score, o_p2_score, o_point_p1, o_point_p2, o_winner};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outs vec %0d: got act=%b s1=%0d s2=%0d pt1=%b pt2=%b win=%b, want act=%b s1=%0d s2=%0d pt1=%b pt2=%b win=%b",
                   n_vec, a.act, a.s1, a.s2, a.pt1, a.pt2, a.win,
                   e.act, e.s1, e.s2, e.pt1, e.pt2, e.win);
        end
      end
    end
  end

  initial begin
    int bx, by, py1, py2;
    bit st;
    // reset state
    cyc(1, 0, 20, 0, 0, 0);
    cyc(1, 0, 20, 0, 0, 0);
    // held start: one serve, play light on from the next cycle
    repeat (10) cyc(0, 1, 20, 5, 0, 0);
    // left miss: ball below paddle rows 10..15
    cyc(0, 1, 0, 20, 10, 10);
    repeat (3) cyc(0, 0, 20, 20, 10, 10);
    // serve, right paddle hit at row 15, then miss at row 16
    cyc(0, 1, 20, 15, 10, 10);
    repeat (4) cyc(0, 1, 39, 15, 10, 10);
    cyc(0, 1, 39, 16, 10, 10);
    repeat (2) cyc(0, 0, 20, 16, 10, 10);
    // paddle at row 63: hit at 63 without wrap, miss at 62
    cyc(0, 1, 20, 63, 63, 0);
    repeat (3) cyc(0, 1, 0, 63, 63, 0);
    cyc(0, 1, 0, 62, 63, 0);
    repeat (2) cyc(0, 0, 20, 0, 0, 0);
    // right misses until player 1 reaches the limit, then more attempts
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 20, 0, 0, 30);
      cyc(0, 1, 20, 0, 0, 30);
      cyc(0, 1, 39, 0, 0, 30);
      cyc(0, 1, 20, 0, 0, 30);
      cyc(0, 1, 20, 0, 0, 30);
    end
    // one edge clears the match
    cyc(0, 0, 20, 0, 0, 0);
    cyc(0, 1, 20, 0, 0, 0);
    cyc(0, 1, 20, 0, 0, 0);
    // three left misses, then reset during the POINT cycle
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 20, 30, 0, 0);
      cyc(0, 1, 20, 30, 0, 0);
      cyc(0, 1, 0, 30, 0, 0);
      if (k < 2) cyc(0, 1, 20, 30, 0, 0);
    end
    cyc(1, 1, 20, 30, 0, 0);
    cyc(0, 1, 20, 30, 0, 0);
    cyc(0, 0, 20, 30, 0, 0);
    // random play
    st = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) st = ~st;
      case ($urandom_range(0, 3))
        0:       bx = 0;
        1:       bx = W - 1;
        default: bx = $urandom_range(1, W - 2);
      endcase
      by  = $urandom_range(0, 63);
      py1 = $urandom_range(0, 1) ? $urandom_range(0, 63) : ((by > 7) ? by - $urandom_range(0, 7) : 0);
      py2 = $urandom_range(0, 1) ? $urandom_range(0, 63) : ((by > 7) ? by - $urandom_range(0, 7) : 0);
      cyc(($urandom_range(0, 299) == 0), st, bx, by, py1, py2);
    end
    // drain, bounded
    repeat (4) @(negedge i_clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
